hp48_bus_ctrl: RTL and testbench

//  Bus master sequencer directly upstream of the peripherals (io_ram, rom, ram): turns one
//  CPU-side nibble-transfer request into the Saturn bus command/nibble sequence.

---
 rtl/hp48_bus_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_hp48_bus_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp48_bus_ctrl.sv
// Saturn bus master sequencer: turns one CPU nibble-transfer request into
// LOAD_PC/LOAD_DP, PC/DP READ/WRITE or CONFIGURE bus cycles.
module hp48_bus_ctrl #(
  parameter logic [3:0] IDLE_CMD = 4'h0
) (
  input  logic        strobe,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_use_dp,
  input  logic [19:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [63:0] req_wdata,
  output logic        rsp_done,
  output logic        rsp_error,
  output logic [63:0] rsp_rdata,
  output logic [3:0]  bus_command,
  output logic [3:0]  bus_nibble_out,
  input  logic [3:0]  bus_nibble_in,
  input  logic        bus_active,
  input  logic        bus_error
);

  localparam logic [3:0] BUSCMD_PC_READ   = 4'h2;
  localparam logic [3:0] BUSCMD_DP_READ   = 4'h3;
  localparam logic [3:0] BUSCMD_PC_WRITE  = 4'h4;
  localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h7;
  localparam logic [3:0] BUSCMD_CONFIGURE = 4'h8;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_CONFIG = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_XFER   = 3'd2,
    S_FINISH = 3'd3,
    S_CONFIG = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  state_t      state_q, state_nx;
  logic [3:0]  cnt_q, cnt_nx;
  logic [1:0]  op_q, op_nx;
  logic        dp_q, dp_nx;
  logic [19:0] addr_q, addr_nx;
  logic [3:0]  len_q, len_nx;
  logic [63:0] wdata_q, wdata_nx;
  logic [63:0] rdata_nx;
  logic [19:0] pc_ptr_q, pc_ptr_nx;
  logic [19:0] dp_ptr_q, dp_ptr_nx;
  logic        pc_valid_q, pc_valid_nx;
  logic        dp_valid_q, dp_valid_nx;
  logic        shadow_hit;

  logic [3:0]  cmd_nx;
  logic [3:0]  nib_nx;
  logic        done_nx;
  logic        error_nx;

  assign req_ready = (state_q == S_IDLE);

  // A matching valid shadow means the peripheral pointer already sits at req_addr.
  assign shadow_hit = req_use_dp ? (dp_valid_q && (dp_ptr_q == req_addr))
                                 : (pc_valid_q && (pc_ptr_q == req_addr));

  // State register plus registered bus/response outputs
  always_ff @(posedge strobe) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      pc_valid_q     <= 1'b0;
      dp_valid_q     <= 1'b0;
      rsp_rdata      <= 64'd0;
      bus_command    <= IDLE_CMD;
      bus_nibble_out <= 4'd0;
      rsp_done       <= 1'b0;
      rsp_error      <= 1'b0;
    end else begin
      state_q        <= state_nx;
      cnt_q          <= cnt_nx;
      pc_valid_q     <= pc_valid_nx;
      dp_valid_q     <= dp_valid_nx;
      rsp_rdata      <= rdata_nx;
      bus_command    <= cmd_nx;
      bus_nibble_out <= nib_nx;
      rsp_done       <= done_nx;
      rsp_error      <= error_nx;
    end
  end

  // Request latch and shadow pointers; meaningful only alongside the valid flags
  always_ff @(posedge strobe) begin
    op_q     <= op_nx;
    dp_q     <= dp_nx;
    addr_q   <= addr_nx;
    len_q    <= len_nx;
    wdata_q  <= wdata_nx;
    pc_ptr_q <= pc_ptr_nx;
    dp_ptr_q <= dp_ptr_nx;
  end

  // Next-state and datapath update
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    op_nx       = op_q;
    dp_nx       = dp_q;
    addr_nx     = addr_q;
    len_nx      = len_q;
    wdata_nx    = wdata_q;
    rdata_nx    = rsp_rdata;
    pc_ptr_nx   = pc_ptr_q;
    dp_ptr_nx   = dp_ptr_q;
    pc_valid_nx = pc_valid_q;
    dp_valid_nx = dp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_nx    = req_op;
          dp_nx    = req_use_dp;
          addr_nx  = req_addr;
          len_nx   = req_len;
          wdata_nx = req_wdata;
          cnt_nx   = 4'd0;
          case (req_op)
            OP_CONFIG: state_nx = S_CONFIG;
            2'b11: begin
              state_nx    = S_ABORT;
              pc_valid_nx = 1'b0;
              dp_valid_nx = 1'b0;
            end
            default: state_nx = shadow_hit ? S_XFER : S_LOAD;
          endcase
        end
      end

      S_LOAD: begin
        if (bus_error) begin
          state_nx = S_ABORT;
          if (dp_q) dp_valid_nx = 1'b0;
          else      pc_valid_nx = 1'b0;
        end else if (cnt_q == 4'd4) begin
          state_nx = S_XFER;
          cnt_nx   = 4'd0;
          if (dp_q) begin
            dp_ptr_nx   = addr_q;
            dp_valid_nx = 1'b1;
          end else begin
            pc_ptr_nx   = addr_q;
            pc_valid_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end

      S_CONFIG: begin
        if (bus_error) begin
          state_nx    = S_ABORT;
          pc_valid_nx = 1'b0;
          dp_valid_nx = 1'b0;
        end else if (cnt_q == 4'd4) begin
          state_nx = S_FINISH;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end

      S_XFER: begin
        if (!bus_active || bus_error) begin
          state_nx = S_ABORT;
          if (dp_q) dp_valid_nx = 1'b0;
          else      pc_valid_nx = 1'b0;
        end else begin
          if (op_q == OP_READ) rdata_nx[{cnt_q, 2'b00} +: 4] = bus_nibble_in;
          // The peripheral pointer steps once per transferred nibble and wraps at 2^20.
          if (dp_q) dp_ptr_nx = dp_ptr_q + 20'd1;
          else      pc_ptr_nx = pc_ptr_q + 20'd1;
          if (cnt_q == len_q) state_nx = S_FINISH;
          else                cnt_nx   = cnt_q + 4'd1;
        end
      end

      S_FINISH: state_nx = S_IDLE;
      S_ABORT:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so bus outputs leave flops
  always_comb begin
    cmd_nx   = IDLE_CMD;
    nib_nx   = 4'd0;
    done_nx  = (state_nx == S_FINISH);
    error_nx = (state_nx == S_ABORT);

    case (state_nx)
      S_LOAD: begin
        cmd_nx = dp_nx ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
        nib_nx = addr_nx[{cnt_nx[2:0], 2'b00} +: 4];
      end
      S_CONFIG: begin
        cmd_nx = BUSCMD_CONFIGURE;
        nib_nx = addr_nx[{cnt_nx[2:0], 2'b00} +: 4];
      end
      S_XFER: begin
        if (op_nx == OP_WRITE) begin
          cmd_nx = dp_nx ? BUSCMD_DP_WRITE : BUSCMD_PC_WRITE;
          nib_nx = wdata_nx[{cnt_nx, 2'b00} +: 4];
        end else begin
          cmd_nx = dp_nx ? BUSCMD_DP_READ : BUSCMD_PC_READ;
        end
      end
      default: begin
        cmd_nx = IDLE_CMD;
        nib_nx = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Self-checking bench for hp48_bus_ctrl: directed vector table, hand-written
// abort/reset sequences, and random requests against a request-level model.
module tb_hp48_bus_ctrl;

  localparam logic [3:0] IDLE_CMD    = 4'h0;
  localparam logic [3:0] C_PC_READ   = 4'h2;
  localparam logic [3:0] C_DP_READ   = 4'h3;
  localparam logic [3:0] C_PC_WRITE  = 4'h4;
  localparam logic [3:0] C_DP_WRITE  = 4'h5;
  localparam logic [3:0] C_LOAD_PC   = 4'h6;
  localparam logic [3:0] C_LOAD_DP   = 4'h7;
  localparam logic [3:0] C_CONFIGURE = 4'h8;

  logic        strobe = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_use_dp;
  logic [19:0] req_addr;
  logic [3:0]  req_len;
  logic [63:0] req_wdata;
  logic        rsp_done;
  logic        rsp_error;
  logic [63:0] rsp_rdata;
  logic [3:0]  bus_command;
  logic [3:0]  bus_nibble_out;
  logic [3:0]  bus_nibble_in = 4'd0;
  logic        bus_active;
  logic        bus_error;
  logic        kill_active = 1'b0;
  logic        inj_error   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign bus_active = ~kill_active;
  assign bus_error  = inj_error;

  always #5 strobe = ~strobe;

  hp48_bus_ctrl #(.IDLE_CMD(IDLE_CMD)) dut (
    .strobe(strobe), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_use_dp(req_use_dp), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .rsp_done(rsp_done), .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata), .bus_command(bus_command),
    .bus_nibble_out(bus_nibble_out), .bus_nibble_in(bus_nibble_in),
    .bus_active(bus_active), .bus_error(bus_error)
  );

  // Peripheral: nibble memory plus its own pc/dp pointers driven by the bus.
  logic [3:0]  mem [0:1048575];
  logic [19:0] r_pc = 20'd0;
  logic [19:0] r_dp = 20'd0;

  always @(posedge strobe) begin
    case (bus_command)
      C_LOAD_PC:  r_pc <= {bus_nibble_out, r_pc[19:4]};
      C_LOAD_DP:  r_dp <= {bus_nibble_out, r_dp[19:4]};
      C_PC_READ:  r_pc <= r_pc + 20'd1;
      C_DP_READ:  r_dp <= r_dp + 20'd1;
      C_PC_WRITE: begin mem[r_pc] <= bus_nibble_out; r_pc <= r_pc + 20'd1; end
      C_DP_WRITE: begin mem[r_dp] <= bus_nibble_out; r_dp <= r_dp + 20'd1; end
      default: ;
    endcase
  end

  always @(negedge strobe) begin
    case (bus_command)
      C_PC_READ: bus_nibble_in <= mem[r_pc];
      C_DP_READ: bus_nibble_in <= mem[r_dp];
      default:   bus_nibble_in <= 4'd0;
    endcase
  end

  // Request-level model: one shadow (valid, pointer) per pointer register.
  bit          m_valid [2];
  logic [19:0] m_ptr   [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] nib_mask(input logic [3:0] len);
    logic [63:0] m = 64'd0;
    for (int k = 0; k <= int'(len); k++) m[4*k +: 4] = 4'hF;
    return m;
  endfunction

  task automatic drive_req(input logic [1:0] op, input logic dp, input logic [19:0] a,
                           input logic [3:0] len, input logic [63:0] wd);
    int w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge strobe);
      w++;
    end
    check("req_ready", 64'(req_ready), 64'd1);
    check("idle_outputs", 64'({bus_command, bus_nibble_out, rsp_done, rsp_error}),
          64'({IDLE_CMD, 4'd0, 2'b00}));
    req_valid = 1'b1; req_op = op; req_use_dp = dp;
    req_addr = a; req_len = len; req_wdata = wd;
    @(posedge strobe);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] op, input logic dp, input logic [19:0] a,
                         input logic [3:0] len, input logic [63:0] wd,
                         output int lat, output logic [3:0] first_cmd);
    logic [3:0]  ec[$];
    logic [3:0]  en[$];
    logic [63:0] exp_rd = 64'd0;
    logic [3:0]  xcmd;
    if (op == 2'b10) begin
      for (int k = 0; k < 5; k++) begin ec.push_back(C_CONFIGURE); en.push_back(a[4*k +: 4]); end
    end else if (op != 2'b11) begin
      if (!(m_valid[dp] && m_ptr[dp] == a))
        for (int k = 0; k < 5; k++) begin
          ec.push_back(dp ? C_LOAD_DP : C_LOAD_PC);
          en.push_back(a[4*k +: 4]);
        end
      if (op == 2'b01) xcmd = dp ? C_DP_WRITE : C_PC_WRITE;
      else             xcmd = dp ? C_DP_READ : C_PC_READ;
      for (int k = 0; k <= int'(len); k++) begin
        ec.push_back(xcmd);
        en.push_back(op == 2'b01 ? wd[4*k +: 4] : 4'd0);
        exp_rd[4*k +: 4] = mem[20'(a + 20'(k))];
      end
    end
    drive_req(op, dp, a, len, wd);
    lat = 0;
    first_cmd = 4'hF;
    for (int c = 1; c <= 40; c++) begin
      @(negedge strobe);
      if (c == 1) first_cmd = bus_command;
      if (c <= ec.size())
        check("bus_cycle", 64'({bus_command, bus_nibble_out, rsp_done, rsp_error}),
              64'({ec[c-1], en[c-1], 2'b00}));
      if (rsp_done || rsp_error) begin lat = c; break; end
    end
    check("latency", 64'(lat), 64'(ec.size() + 1));
    check("resp_pulse", 64'({rsp_done, rsp_error}), (op == 2'b11) ? 64'd1 : 64'd2);
    if (op == 2'b00) check("rdata_model", rsp_rdata & nib_mask(len), exp_rd);
    if (op == 2'b11) begin
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    end else if (op != 2'b10) begin
      m_valid[dp] = 1'b1;
      m_ptr[dp]   = 20'(a + 20'(len) + 20'd1);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        dp;
    logic [19:0] addr;
    logic [3:0]  len;
    logic [63:0] wd;
    logic [3:0]  first;
    int          lat;
    bit          chk_rd;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [3:0]  fc;
    logic [1:0]  rop;
    logic        rdp;
    logic [19:0] ra;
    logic [3:0]  rl;

    // Untouched memory holds a[3:0]^a[11:8]^5.
    for (int i = 0; i < 1048576; i++) begin
      ra = 20'(i);
      mem[i] = ra[3:0] ^ ra[11:8] ^ 4'h5;
    end
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_ptr[0] = 20'd0; m_ptr[1] = 20'd0;

    tbl[0] = '{2'b00, 1'b0, 20'h00100, 4'd3, 64'd0,      C_LOAD_PC,   10, 1'b1, 64'h7654};
    tbl[1] = '{2'b00, 1'b0, 20'h00104, 4'd0, 64'd0,      C_PC_READ,   2,  1'b1, 64'h0};
    tbl[2] = '{2'b01, 1'b1, 20'hFFFFE, 4'd3, 64'h4321,   C_LOAD_DP,   10, 1'b0, 64'h0};
    tbl[3] = '{2'b00, 1'b1, 20'h00002, 4'd1, 64'd0,      C_DP_READ,   3,  1'b1, 64'h67};
    tbl[4] = '{2'b10, 1'b0, 20'h00100, 4'd0, 64'd0,      C_CONFIGURE, 6,  1'b0, 64'h0};
    tbl[5] = '{2'b00, 1'b0, 20'h00105, 4'd0, 64'd0,      C_PC_READ,   2,  1'b1, 64'h1};
    tbl[6] = '{2'b00, 1'b1, 20'h00004, 4'd0, 64'd0,      C_DP_READ,   2,  1'b1, 64'h1};
    tbl[7] = '{2'b11, 1'b0, 20'h00106, 4'd0, 64'd0,      IDLE_CMD,    1,  1'b0, 64'h0};
    tbl[8] = '{2'b00, 1'b0, 20'h00106, 4'd0, 64'd0,      C_LOAD_PC,   7,  1'b1, 64'h2};
    tbl[9] = '{2'b00, 1'b1, 20'h00000, 4'd1, 64'd0,      C_LOAD_DP,   8,  1'b1, 64'h43};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_use_dp = 1'b0;
    req_addr = 20'd0; req_len = 4'd0; req_wdata = 64'd0;
    repeat (3) @(posedge strobe);
    @(negedge strobe);
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_bus", 64'({bus_command, bus_nibble_out}), 64'({IDLE_CMD, 4'd0}));
    check("reset_pulses", 64'({rsp_done, rsp_error}), 64'd0);
    check("reset_rdata", rsp_rdata, 64'd0);
    @(posedge strobe);
    #1 reset = 1'b0;
    @(negedge strobe);

    for (int i = 0; i < 10; i++) begin
      run_req(tbl[i].op, tbl[i].dp, tbl[i].addr, tbl[i].len, tbl[i].wd, lat, fc);
      check($sformatf("vec%0d_first_cmd", i), 64'(fc), 64'(tbl[i].first));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      if (tbl[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), rsp_rdata & nib_mask(tbl[i].len), tbl[i].rd);
    end

    // bus_active dropped on XFER nibble 2 of a PC read
    drive_req(2'b00, 1'b0, 20'h00200, 4'd3, 64'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge strobe);
      if (c == 8) begin
        check("xfer2_cmd", 64'({bus_command, rsp_done, rsp_error}), 64'({C_PC_READ, 2'b00}));
        kill_active = 1'b1;
      end
      if (c == 9) begin
        kill_active = 1'b0;
        check("xfer_abort_pulse", 64'({rsp_done, rsp_error}), 64'd1);
        check("xfer_abort_cmd", 64'(bus_command), 64'(IDLE_CMD));
      end
    end
    m_valid[0] = 1'b0;
    run_req(2'b00, 1'b0, 20'h00200, 4'd3, 64'd0, lat, fc);
    check("reload_after_xfer_abort", 64'(fc), 64'(C_LOAD_PC));

    // bus_error during LOAD_DP
    drive_req(2'b00, 1'b1, 20'h12345, 4'd2, 64'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge strobe);
      if (c == 3) inj_error = 1'b1;
      if (c == 4) begin
        inj_error = 1'b0;
        check("load_abort_pulse", 64'({rsp_done, rsp_error}), 64'd1);
      end
    end
    m_valid[1] = 1'b0;
    run_req(2'b00, 1'b1, 20'h12345, 4'd0, 64'd0, lat, fc);
    check("reload_after_load_abort", 64'(fc), 64'(C_LOAD_DP));

    // bus_error during CONFIGURE invalidates both shadows
    drive_req(2'b10, 1'b0, 20'h00500, 4'd0, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge strobe);
      if (c == 2) inj_error = 1'b1;
      if (c == 3) begin
        inj_error = 1'b0;
        check("config_abort_pulse", 64'({rsp_done, rsp_error}), 64'd1);
      end
    end
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    run_req(2'b00, 1'b0, 20'h00204, 4'd0, 64'd0, lat, fc);
    check("pc_reload_after_cfg_abort", 64'(fc), 64'(C_LOAD_PC));
    run_req(2'b00, 1'b1, 20'h12346, 4'd0, 64'd0, lat, fc);
    check("dp_reload_after_cfg_abort", 64'(fc), 64'(C_LOAD_DP));

    // reset asserted in XFER nibble 1
    drive_req(2'b00, 1'b0, 20'h00300, 4'd7, 64'd0);
    for (int c = 1; c <= 7; c++) @(negedge strobe);
    reset = 1'b1;
    @(posedge strobe);
    #1 reset = 1'b0;
    @(negedge strobe);
    check("midop_reset_bus", 64'({bus_command, bus_nibble_out, req_ready}),
          64'({IDLE_CMD, 4'd0, 1'b1}));
    check("midop_reset_rdata", rsp_rdata, 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("midop_reset_pulses", 64'({rsp_done, rsp_error}), 64'd0);
      @(negedge strobe);
    end
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    run_req(2'b00, 1'b0, 20'h00301, 4'd0, 64'd0, lat, fc);
    check("reload_after_reset", 64'(fc), 64'(C_LOAD_PC));

    // Random requests against the model
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 19);
      rop = (r < 8) ? 2'b00 : (r < 16) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      rdp = 1'($urandom_range(0, 1));
      rl  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1:    ra = m_valid[rdp] ? m_ptr[rdp] : 20'($urandom);
        2:       ra = 20'hFFFF0 + 20'($urandom_range(0, 15));
        default: ra = 20'($urandom);
      endcase
      run_req(rop, rdp, ra, rl, {$urandom, $urandom}, lat, fc);
    end

    @(negedge strobe);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
